sipo_deserializer: RTL and testbench

//  Serial-in/parallel-out deserializer: the receive end of the team's PISO serial link.

---
 rtl/sipo_deserializer.sv | 123 ++++++++++++
 tb/tb_sipo_deserializer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out deserializer with a one-word output holding register.
// Optional even-parity checking is enabled by defining SIPO_PARITY_EN.
module sipo_deserializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ser_in,
  input  logic             ser_valid,
  output logic             ser_ready,
  output logic [WIDTH-1:0] par_out,
  output logic             par_valid,
  input  logic             par_ready,
  output logic             par_err
);

`ifdef SIPO_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic {COLLECT = 1'b0, STALL = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] bit_cnt;
  logic [WIDTH-1:0] sreg, sreg_nxt;
  logic             accept, word_done, load_now, unload_stall;

  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur, input logic b);
    if (MSB_FIRST) return {cur[WIDTH-2:0], b};
    else           return {b, cur[WIDTH-1:1]};
  endfunction

  assign accept       = ser_valid & ser_ready;
  assign word_done    = accept & (bit_cnt == CNT_W'(NBITS - 1));
  assign load_now     = word_done & (~par_valid | par_ready);
  assign unload_stall = (state == STALL) & par_ready;

`ifdef SIPO_PARITY_EN
  // The trailing parity bit is not shifted into the data register.
  assign sreg_nxt = (bit_cnt == CNT_W'(WIDTH)) ? sreg : shift_in(sreg, ser_in);
`else
  assign sreg_nxt = shift_in(sreg, ser_in);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= COLLECT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      COLLECT: if (word_done && par_valid && !par_ready) state_nxt = STALL;
      STALL:   if (par_ready) state_nxt = COLLECT;
      default: state_nxt = COLLECT;
    endcase
  end

  always_comb begin
    ser_ready = (state == COLLECT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_cnt   <= '0;
      sreg      <= '0;
      par_out   <= '0;
      par_valid <= 1'b0;
    end else begin
      if (load_now) begin
        par_out   <= sreg_nxt;
        par_valid <= 1'b1;
      end else if (unload_stall) begin
        par_out   <= sreg;
        par_valid <= 1'b1;
      end else if (par_valid && par_ready) begin
        par_valid <= 1'b0;
      end

      // A completed word that cannot be handed off stays in sreg until STALL drains.
      if (accept) begin
        if (word_done) begin
          bit_cnt <= load_now ? '0 : bit_cnt;
          sreg    <= load_now ? '0 : sreg_nxt;
        end else begin
          bit_cnt <= bit_cnt + CNT_W'(1);
          sreg    <= sreg_nxt;
        end
      end else if (unload_stall) begin
        bit_cnt <= '0;
        sreg    <= '0;
      end
    end
  end

`ifdef SIPO_PARITY_EN
  logic par_acc, par_acc_nxt, par_err_q;

  assign par_acc_nxt = par_acc ^ ser_in;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      par_acc   <= 1'b0;
      par_err_q <= 1'b0;
    end else begin
      if (load_now)          par_err_q <= par_acc_nxt;
      else if (unload_stall) par_err_q <= par_acc;

      if (accept)            par_acc <= load_now ? 1'b0 : par_acc_nxt;
      else if (unload_stall) par_acc <= 1'b0;
    end
  end

  assign par_err = par_err_q;
`else
  assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_deserializer.sv
// Scoreboard bench for sipo_deserializer: directed scenarios plus randomized traffic,
// running an MSB-first and an LSB-first instance in lockstep.
module tb_sipo_deserializer;

  localparam int W = 4;
`ifdef SIPO_PARITY_EN
  localparam bit PAR = 1'b1;
  localparam int NB  = W + 1;
`else
  localparam bit PAR = 1'b0;
  localparam int NB  = W;
`endif

  typedef struct {
    logic [W-1:0] msb;
    logic [W-1:0] lsb;
    logic         err;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n, ser_in, ser_valid, par_ready;
  logic         ser_ready, par_valid, par_err;
  logic [W-1:0] par_out;
  logic         l_ser_ready, l_par_valid, l_par_err;
  logic [W-1:0] l_par_out;

  exp_t         exp_q[$];
  int           tests = 0;
  int           fails = 0;
  int           sent = 0;
  int           consumed = 0;
  bit           rnd_ready = 1'b0;
  bit           hold = 1'b0;
  logic [W-1:0] hold_data;

  always #5 clk = ~clk;

  sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .ser_in(ser_in), .ser_valid(ser_valid),
    .ser_ready(ser_ready), .par_out(par_out), .par_valid(par_valid),
    .par_ready(par_ready), .par_err(par_err)
  );

  sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .ser_in(ser_in), .ser_valid(ser_valid),
    .ser_ready(l_ser_ready), .par_out(l_par_out), .par_valid(l_par_valid),
    .par_ready(par_ready), .par_err(l_par_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: serial order is d[W-1] first; MSB-first keeps d, LSB-first puts the first bit at [0].
  task automatic push_exp(input logic [W-1:0] d, input logic bad);
    exp_t e;
    e.msb = d;
    for (int i = 0; i < W; i++) e.lsb[i] = d[W-1-i];
    e.err = bad & PAR;
    exp_q.push_back(e);
    sent++;
  endtask

  function automatic logic [NB-1:0] ser_vec(input logic [W-1:0] d, input logic bad);
    logic [NB-1:0] v;
    for (int i = 0; i < W; i++) v[i] = d[W-1-i];
`ifdef SIPO_PARITY_EN
    v[W] = (^d) ^ bad;
`endif
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_ready) par_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic idle(input int n);
    ser_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic send_bit(input logic b);
    logic a;
    int   n = 0;
    ser_in    = b;
    ser_valid = 1'b1;
    do begin
      @(negedge clk);
      a = ser_ready;
      tick();
      n++;
    end while (!a && n < 200);
    if (!a) check("ser_accept_timeout", 32'(a), 32'd1);
    ser_valid = 1'b0;
  endtask

  task automatic send_word(input logic [W-1:0] d, input logic bad, input int gap);
    logic [NB-1:0] v;
    v = ser_vec(d, bad);
    push_exp(d, bad);
    for (int k = 0; k < NB; k++) begin
      if (k != 0 && gap > 0) idle(gap);
      send_bit(v[k]);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        check("hold_valid", 32'(par_valid), 32'd1);
        check("hold_data", 32'(par_out), 32'(hold_data));
      end
      if (par_valid && par_ready) begin
        check("word_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          exp_t e;
          e = exp_q.pop_front();
          consumed++;
          check("par_out_msb", 32'(par_out), 32'(e.msb));
          check("par_out_lsb", 32'(l_par_out), 32'(e.lsb));
          check("lsb_valid", 32'(l_par_valid), 32'd1);
          check("par_err", 32'(par_err), 32'(e.err));
        end
      end
      hold      = par_valid && !par_ready;
      hold_data = par_out;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NB-1:0] v;
    rst_n = 1'b0; ser_in = 1'b0; ser_valid = 1'b0; par_ready = 1'b0;

    // Reset for two edges
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_par_valid", 32'(par_valid), 32'd0);
    check("rst_par_out", 32'(par_out), 32'd0);
    check("rst_par_err", 32'(par_err), 32'd0);
    check("rst_ser_ready", 32'(ser_ready), 32'd1);

    // Basic word with one-cycle latency and single-cycle valid
    par_ready = 1'b1;
    send_word(4'b1011, 1'b0, 0);
    check("basic_valid", 32'(par_valid), 32'd1);
    check("basic_msb", 32'(par_out), 32'hB);
    check("basic_lsb", 32'(l_par_out), 32'hD);
    tick();
    check("basic_valid_drop", 32'(par_valid), 32'd0);

    // Backpressure: A then 5 back to back with consumer stalled
    par_ready = 1'b0;
    send_word(4'hA, 1'b0, 0);
    send_word(4'h5, 1'b0, 0);
    check("bp_ser_ready", 32'(ser_ready), 32'd0);
    check("bp_hold_A", 32'(par_out), 32'hA);
    check("bp_valid", 32'(par_valid), 32'd1);
    par_ready = 1'b1;
    tick();
    check("bp_next_5", 32'(par_out), 32'h5);
    check("bp_ready_back", 32'(ser_ready), 32'd1);
    idle(3);

    // Gapped bits, then a reset in the middle of a word
    send_word(4'h6, 1'b0, 1);
    idle(3);
    send_bit(1'b1);
    send_bit(1'b1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_valid", 32'(par_valid), 32'd0);
    send_word(4'h3, 1'b0, 0);
    check("after_rst_word", 32'(par_out), 32'h3);
    idle(2);

    // Consume of word X coincides with arrival of Y's last bit
    par_ready = 1'b0;
    send_word(4'h9, 1'b0, 0);
    v = ser_vec(4'hE, 1'b0);
    push_exp(4'hE, 1'b0);
    for (int k = 0; k < NB - 1; k++) send_bit(v[k]);
    par_ready = 1'b1;
    send_bit(v[NB-1]);
    check("nobubble_valid", 32'(par_valid), 32'd1);
    check("nobubble_data", 32'(par_out), 32'hE);
    idle(2);

`ifdef SIPO_PARITY_EN
    send_word(4'hB, 1'b0, 0);
    check("parity_ok_err", 32'(par_err), 32'd0);
    idle(1);
    send_word(4'hB, 1'b1, 0);
    check("parity_bad_err", 32'(par_err), 32'd1);
    check("parity_bad_data", 32'(par_out), 32'hB);
    idle(1);
`endif

    // Randomized traffic with a randomly stalling consumer
    rnd_ready = 1'b1;
    repeat (60) send_word(W'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 2));
    rnd_ready = 1'b0;
    par_ready = 1'b1;
    idle(10);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("words_consumed", 32'(consumed), 32'(sent));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
